vga_capture: RTL

- Video-capture counterpart of the display controller. Samples a parallel video stream (HS/VS/BLANK/RGB) and writes every active pixel into a framebuffer through a Wishbone master doing classic single write cycles.
- Pixel n of a frame goes to BASE + 4*n, the same framebuffer layout the display side reads.
- Video input and Wishbone port share one clock. An internal synchronous FIFO absorbs bus stalls.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/vga_capture.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared video definitions for the capture and display sides.
// Holds the panel timing constants, the capture FSM state encoding and
// the FIFO entry layout used between the capture and bus-write stages.
package vga_pkg;

    // Panel timing (pixels / lines), shared with the display controller
    localparam int unsigned HFP    = 40;
    localparam int unsigned HPULSE = 48;
    localparam int unsigned HBP    = 40;
    localparam int unsigned VFP    = 13;
    localparam int unsigned VPULSE = 3;
    localparam int unsigned VBP    = 29;

    localparam int unsigned RGB_W  = 24;
    localparam int unsigned PAD_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } cap_state_e;

    // sof marks the first pixel of a frame so the write side can resync
    typedef struct packed {
        logic             sof;
        logic [PAD_W-1:0] pad;
        logic [RGB_W-1:0] rgb;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and registered full/empty flags.
// The head entry is always presented on rd_data (first-word fall-through).
// Ports: clk, rst_n, push/wr_data (write), pop/rd_data (read), full, empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign rd_data   = mem[rd_ptr];

    // Occupancy bookkeeping
    always_comb begin
        count_next_c = count;
        case ({do_push_c, do_pop_c})
            2'b10:   count_next_c = count + CW'(1);
            2'b01:   count_next_c = count - CW'(1);
            default: count_next_c = count;
        endcase
    end

    // Pointers and flags (depth is a power of two, pointers wrap naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next_c;
            full  <= (count_next_c == CW'(DEPTH));
            empty <= (count_next_c == CW'(0));
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vga_capture.sv
// Video capture: samples a parallel video stream and writes each active pixel
// of a frame to BASE + 4*n via classic single Wishbone write cycles.
// Ports: pixel_clk/pixel_rst_n, enable, base_adr, clear_status, vid_* (input
// video), wshb_* (Wishbone master), frame_done (pulse), overflow (sticky).
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic        enable,
    input  logic [31:0] base_adr,
    input  logic        clear_status,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_blank,
    input  logic [23:0] vid_rgb,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    input  logic        wshb_ack,
    output logic        frame_done,
    output logic        overflow
);

    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned ID_W = $clog2(NPIX);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NPIX - 1);

    // Input stage
    logic        hs_q;
    logic        vs_q;
    logic        vs_prev;
    logic        blank_q;
    logic [23:0] rgb_q;

    cap_state_e     state;
    logic [ID_W-1:0] cap_cnt;
    logic [ID_W-1:0] wr_id;

    logic        sof_c;
    logic        pixel_c;
    logic        push_c;
    logic        drop_c;
    logic        pop_c;
    fifo_entry_t push_entry_c;
    fifo_entry_t pop_entry_c;
    logic [ID_W-1:0] wr_id_next_c;

    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;

    assign wshb_we  = 1'b1;
    assign wshb_sel = 4'hF;
    assign wshb_cti = 3'b000;
    assign wshb_bte = 2'b00;
    assign wshb_stb = wshb_cyc;

    // Register the video inputs once; hsync is carried for alignment only
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hs_q    <= vid_hs;
            vs_q    <= vid_vs;
            vs_prev <= vs_q;
            blank_q <= vid_blank & hs_q | vid_blank;
            rgb_q   <= vid_rgb;
        end
    end

    // Frame start is a falling edge of the registered vsync
    assign sof_c   = vs_prev && !vs_q;
    assign pixel_c = ((state == ARMED) || (state == CAPTURE)) && blank_q && !sof_c;
    assign pop_c   = !wshb_cyc && !fifo_empty;
    // A full FIFO still accepts a pixel when the write side pops this cycle
    assign push_c  = pixel_c && (!fifo_full || pop_c);
    assign drop_c  = pixel_c && fifo_full && !pop_c;

    always_comb begin
        push_entry_c     = '0;
        push_entry_c.sof = (state == ARMED);
        push_entry_c.pad = '0;
        push_entry_c.rgb = rgb_q;
    end

    // Capture FSM and sticky overflow flag
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state    <= IDLE;
            cap_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clear_status) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sof_c && enable) begin
                        state   <= ARMED;
                        cap_cnt <= '0;
                    end
                end
                ARMED, CAPTURE: begin
                    if (sof_c) begin
                        // Short frame: restart, or stop if capture was disabled
                        state   <= enable ? ARMED : IDLE;
                        cap_cnt <= '0;
                    end else if (drop_c) begin
                        state <= DONE;
                    end else if (push_c) begin
                        cap_cnt <= cap_cnt + ID_W'(1);
                        state   <= (cap_cnt == LAST_ID) ? DONE : CAPTURE;
                    end
                end
                DONE: begin
                    if (sof_c) begin
                        state   <= enable ? ARMED : IDLE;
                        cap_cnt <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cap_cnt <= '0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst_n   (pixel_rst_n),
        .push    (push_c),
        .wr_data (push_entry_c),
        .pop     (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pop_entry_c  = fifo_entry_t'(fifo_rd_data);
    assign wr_id_next_c = pop_entry_c.sof ? '0 : wr_id + ID_W'(1);

    // Wishbone write side: one single cycle per entry, one idle cycle after ack
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            wshb_cyc    <= 1'b0;
            wshb_adr    <= '0;
            wshb_dat_ms <= '0;
            wr_id       <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (wshb_cyc) begin
                if (wshb_ack) begin
                    wshb_cyc   <= 1'b0;
                    frame_done <= (wr_id == LAST_ID);
                end
            end else if (pop_c) begin
                wshb_cyc    <= 1'b1;
                wr_id       <= wr_id_next_c;
                wshb_adr    <= base_adr + 32'({wr_id_next_c, 2'b00});
                wshb_dat_ms <= {pop_entry_c.pad, pop_entry_c.rgb};
            end
        end
    end

endmodule
